toom8_sched: RTL and testbench

Sequencing controller for the TOOM_8 1024×1024 multiplier. It accepts an operand-pair start, triggers operand evaluation (8 limbs of 128 bits, 129-bit evaluated chunks), and issues the 15 Toom-8 pointwise products to a shared pointwise multiplier over a valid/ready request channel. It tracks the out-of-order responses, starts interpolation once all 15 have returned, and signals completion.

---
 rtl/toom8_pkg.sv | 25 ++
 rtl/toom8_rsp_tracker.sv | 87 ++++++++
 rtl/toom8_sched.sv | 147 ++++++++++++++
 tb/tb_toom8_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toom8_pkg.sv
// Shared constants and state encoding for the TOOM_8 multiplier sequencer.
// Imported by toom8_sched and toom8_rsp_tracker.
package toom8_pkg;

   localparam int NUM_POINTS = 15;
   localparam int IDX_W      = 4;
   localparam int LIMB_W     = 128;
   localparam int CHUNK_W    = 129;

   localparam logic [NUM_POINTS-1:0] ALL_DONE_MASK = 15'h7FFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVAL,
      S_ISSUE,
      S_WAIT,
      S_INTERP,
      S_FIN
   } state_t;

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return idx < IDX_W'(NUM_POINTS);
   endfunction

endpackage

// File: rtl/toom8_rsp_tracker.sv
// Pointwise response bookkeeping: returned-index mask, in-flight count and
// protocol error detection.
// Ports: clr_i (new job), active_i (ISSUE/WAIT), req_fire_i (request handshake),
//   rsp_valid_i/rsp_idx_i (response), can_issue_o (outst below limit),
//   all_done_o (every point returned), err_o (sticky protocol error).
module toom8_rsp_tracker
   import toom8_pkg::*;
#(
   parameter int MAX_OUTST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             active_i,
   input  logic             req_fire_i,
   input  logic             rsp_valid_i,
   input  logic [IDX_W-1:0] rsp_idx_i,
   output logic             can_issue_o,
   output logic             all_done_o,
   output logic             err_o
);

   localparam logic [IDX_W-1:0] OUTST_MAX = IDX_W'(MAX_OUTST);

   logic [NUM_POINTS-1:0] mask_q, mask_d;
   logic [IDX_W-1:0]      outst_q, outst_d;
   logic                  err_q, err_d;

   logic [15:0]           mask_ext;
   logic [NUM_POINTS-1:0] onehot;
   logic                  rsp_seen;
   logic                  rsp_bad;
   logic                  rsp_ok;

   always_comb begin
      // Padded copy so that idx 15 reads as "not set" rather than out of range.
      mask_ext = {1'b0, mask_q};
      onehot   = NUM_POINTS'(1) << rsp_idx_i;
      rsp_seen = active_i && rsp_valid_i;
      rsp_bad  = !idx_in_range(rsp_idx_i)
               || mask_ext[rsp_idx_i]
               || (outst_q == '0);
      rsp_ok   = rsp_seen && !rsp_bad;

      mask_d  = mask_q;
      outst_d = outst_q;
      err_d   = err_q;

      if (rsp_ok) begin
         mask_d = mask_q | onehot;
      end

      // A request and a response in the same cycle cancel out.
      unique case ({req_fire_i, rsp_ok})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      if (rsp_seen && rsp_bad) begin
         err_d = 1'b1;
      end

      if (clr_i) begin
         mask_d  = '0;
         outst_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q  <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   assign can_issue_o = outst_q < OUTST_MAX;
   assign all_done_o  = mask_q == ALL_DONE_MASK;
   assign err_o       = err_q;

endmodule

// File: rtl/toom8_sched.sv
// TOOM_8 sequencer: evaluation trigger, in-order issue of 15 pointwise
// products, out-of-order response tracking, interpolation handoff.
// Ports: start_valid/start_ready (job start), eval_load (evaluation pulse),
//   mul_req_* (pointwise request), mul_rsp_* (pointwise result),
//   interp_start/interp_done (interpolation), done, busy, err, cycles.
module toom8_sched
   import toom8_pkg::*;
#(
   parameter int EVAL_CYCLES = 2,
   parameter int MAX_OUTST   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   output logic             eval_load,
   output logic             mul_req_valid,
   input  logic             mul_req_ready,
   output logic [IDX_W-1:0] mul_req_idx,
   input  logic             mul_rsp_valid,
   input  logic [IDX_W-1:0] mul_rsp_idx,
   output logic             interp_start,
   input  logic             interp_done,
   output logic             done,
   output logic             busy,
   output logic             err,
   output logic [15:0]      cycles
);

   localparam logic [3:0]       EV_LAST  = 4'(EVAL_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

   state_t           state_q, state_d;
   logic [3:0]       ev_cnt_q, ev_cnt_d;
   logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [15:0]      cyc_q, cyc_d;
   logic             istart_q, istart_d;

   logic accept;
   logic req_fire;
   logic can_issue;
   logic all_done;
   logic trk_active;

   assign accept     = (state_q == S_IDLE) && start_valid;
   assign req_fire   = mul_req_valid && mul_req_ready;
   assign trk_active = (state_q == S_ISSUE) || (state_q == S_WAIT);

   toom8_rsp_tracker #(
      .MAX_OUTST (MAX_OUTST)
   ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (accept),
      .active_i    (trk_active),
      .req_fire_i  (req_fire),
      .rsp_valid_i (mul_rsp_valid),
      .rsp_idx_i   (mul_rsp_idx),
      .can_issue_o (can_issue),
      .all_done_o  (all_done),
      .err_o       (err)
   );

   always_comb begin
      state_d     = state_q;
      ev_cnt_d    = ev_cnt_q;
      issue_cnt_d = issue_cnt_q;
      istart_d    = 1'b0;
      cyc_d       = cyc_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               state_d     = S_EVAL;
               ev_cnt_d    = '0;
               issue_cnt_d = '0;
            end
         end
         S_EVAL: begin
            if (ev_cnt_q == EV_LAST) begin
               state_d = S_ISSUE;
            end else begin
               ev_cnt_d = ev_cnt_q + 1'b1;
            end
         end
         S_ISSUE: begin
            if (req_fire) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == LAST_IDX) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Registered mask: a response landing with the last request is
            // seen here one cycle later.
            if (all_done) begin
               state_d  = S_INTERP;
               istart_d = 1'b1;
            end
         end
         S_INTERP: begin
            if (interp_done) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         cyc_d = '0;
      end else if ((state_q != S_IDLE) && (cyc_q != 16'hFFFF)) begin
         cyc_d = cyc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ev_cnt_q    <= '0;
         issue_cnt_q <= '0;
         cyc_q       <= '0;
         istart_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ev_cnt_q    <= ev_cnt_d;
         issue_cnt_q <= issue_cnt_d;
         cyc_q       <= cyc_d;
         istart_q    <= istart_d;
      end
   end

   assign start_ready   = state_q == S_IDLE;
   assign busy          = state_q != S_IDLE;
   assign eval_load     = (state_q == S_EVAL) && (ev_cnt_q == '0);
   assign mul_req_valid = (state_q == S_ISSUE) && can_issue;
   assign mul_req_idx   = issue_cnt_q;
   assign interp_start  = istart_q;
   assign done          = state_q == S_FIN;
   assign cycles        = cyc_q;

endmodule

// File: tb/tb_toom8_sched.sv
// Directed bench for toom8_sched: one instance with default limits and one
// with MAX_OUTST=15 for the fully out-of-order return.
module tb_toom8_sched;

   logic        clk;
   logic        rst;
   logic        sv   [2];
   logic        rdy  [2];
   logic        rv   [2];
   logic [3:0]  rid  [2];
   logic        idn  [2];
   logic        sr   [2];
   logic        el   [2];
   logic        mv   [2];
   logic [3:0]  mi   [2];
   logic        ist  [2];
   logic        dn   [2];
   logic        bz   [2];
   logic        er   [2];
   logic [15:0] cyc  [2];

   int n_chk;
   int n_fail;

   toom8_sched #(.EVAL_CYCLES(2), .MAX_OUTST(4)) u_dut0 (
      .clk           (clk),
      .rst           (rst),
      .start_valid   (sv[0]),
      .start_ready   (sr[0]),
      .eval_load     (el[0]),
      .mul_req_valid (mv[0]),
      .mul_req_ready (rdy[0]),
      .mul_req_idx   (mi[0]),
      .mul_rsp_valid (rv[0]),
      .mul_rsp_idx   (rid[0]),
      .interp_start  (ist[0]),
      .interp_done   (idn[0]),
      .done          (dn[0]),
      .busy          (bz[0]),
      .err           (er[0]),
      .cycles        (cyc[0])
   );

   toom8_sched #(.EVAL_CYCLES(2), .MAX_OUTST(15)) u_dut1 (
      .clk           (clk),
      .rst           (rst),
      .start_valid   (sv[1]),
      .start_ready   (sr[1]),
      .eval_load     (el[1]),
      .mul_req_valid (mv[1]),
      .mul_req_ready (rdy[1]),
      .mul_req_idx   (mi[1]),
      .mul_rsp_valid (rv[1]),
      .mul_rsp_idx   (rid[1]),
      .interp_start  (ist[1]),
      .interp_done   (idn[1]),
      .done          (dn[1]),
      .busy          (bz[1]),
      .err           (er[1]),
      .cycles        (cyc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       sv;
      logic       rdy;
      logic       rv;
      logic [3:0] rid;
      logic       e_sr;
      logic       e_el;
      logic       e_mv;
      logic [3:0] e_mi;
      logic       e_bz;
      logic       e_er;
   } vec_t;

   vec_t tv [21];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int tag, input int got,
                      input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, tag, got, exp);
      end
   endtask

   task automatic setv(input int i, input logic r, input logic s,
                       input logic rd, input logic v, input logic [3:0] id,
                       input logic esr, input logic eel, input logic emv,
                       input logic [3:0] emi, input logic ebz,
                       input logic eer);
      tv[i].rst  = r;
      tv[i].sv   = s;
      tv[i].rdy  = rd;
      tv[i].rv   = v;
      tv[i].rid  = id;
      tv[i].e_sr = esr;
      tv[i].e_el = eel;
      tv[i].e_mv = emv;
      tv[i].e_mi = emi;
      tv[i].e_bz = ebz;
      tv[i].e_er = eer;
   endtask

   initial begin
      int issued;
      int resp;
      int nist;
      int ist_c;
      int dcyc;
      int maxinf;
      int first_el;
      int first_mv;
      int c_last;
      int c0;
      int k;
      int dueq [$];
      int idxq [$];

      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      for (int d = 0; d < 2; d++) begin
         sv[d]  = 1'b0;
         rdy[d] = 1'b0;
         rv[d]  = 1'b0;
         rid[d] = 4'd0;
         idn[d] = 1'b0;
      end

      //      i  rst sv rdy rv rid | sr el mv mi bz er
      setv( 0, 0, 1, 0, 0, 4'd0,  1, 0, 0, 4'd0, 0, 0);
      setv( 1, 0, 0, 0, 0, 4'd0,  0, 1, 0, 4'd0, 1, 0);
      setv( 2, 0, 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 1, 0);
      setv( 3, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd0, 1, 0);
      setv( 4, 0, 0, 0, 0, 4'd0,  0, 0, 1, 4'd1, 1, 0);
      setv( 5, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd1, 1, 0);
      setv( 6, 0, 0, 0, 0, 4'd0,  0, 0, 1, 4'd2, 1, 0);
      setv( 7, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd2, 1, 0);
      setv( 8, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd3, 1, 0);
      setv( 9, 0, 0, 1, 1, 4'd0,  0, 0, 0, 4'd4, 1, 0);
      setv(10, 0, 0, 1, 1, 4'd1,  0, 0, 1, 4'd4, 1, 0);
      setv(11, 0, 0, 0, 0, 4'd0,  0, 0, 1, 4'd5, 1, 0);
      setv(12, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd5, 1, 0);
      setv(13, 0, 0, 1, 1, 4'd1,  0, 0, 0, 4'd6, 1, 0);
      setv(14, 0, 0, 1, 1, 4'd15, 0, 0, 0, 4'd6, 1, 1);
      setv(15, 0, 0, 1, 1, 4'd5,  0, 0, 0, 4'd6, 1, 1);
      setv(16, 0, 0, 1, 0, 4'd0,  0, 0, 1, 4'd6, 1, 1);
      setv(17, 1, 0, 0, 0, 4'd0,  0, 0, 0, 4'd7, 1, 1);
      setv(18, 0, 0, 0, 1, 4'd2,  1, 0, 0, 4'd0, 0, 0);
      setv(19, 0, 0, 0, 1, 4'd3,  1, 0, 0, 4'd0, 0, 0);
      setv(20, 0, 0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 0, 0);

      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Table: reset state, eval timing, backpressure, concurrent
      // request/response at outst=3, errors, reset mid-ISSUE, stale rsp.
      for (int i = 0; i < 21; i++) begin
         chk("T_start_ready", i, int'(sr[0]), int'(tv[i].e_sr));
         chk("T_eval_load", i, int'(el[0]), int'(tv[i].e_el));
         chk("T_req_valid", i, int'(mv[0]), int'(tv[i].e_mv));
         chk("T_req_idx", i, int'(mi[0]), int'(tv[i].e_mi));
         chk("T_busy", i, int'(bz[0]), int'(tv[i].e_bz));
         chk("T_err", i, int'(er[0]), int'(tv[i].e_er));
         rst    = tv[i].rst;
         sv[0]  = tv[i].sv;
         rdy[0] = tv[i].rdy;
         rv[0]  = tv[i].rv;
         rid[0] = tv[i].rid;
         tick();
      end

      // Ideal path: ready=1, in-order responses 3 cycles after accept.
      issued   = 0;
      resp     = 0;
      nist     = 0;
      ist_c    = -10;
      dcyc     = 0;
      maxinf   = 0;
      first_el = 0;
      first_mv = 0;
      chk("B_start_ready", 0, int'(sr[0]), 1);
      sv[0] = 1'b1;
      tick();
      sv[0] = 1'b0;
      for (int c = 1; c <= 200 && dcyc == 0; c++) begin
         rdy[0] = 1'b1;
         rv[0]  = 1'b0;
         rid[0] = 4'd0;
         idn[0] = 1'b0;
         if (el[0] && first_el == 0) first_el = c;
         if (mv[0]) begin
            if (first_mv == 0) first_mv = c;
            chk("B_req_idx", issued, int'(mi[0]), issued);
            if (issued - resp + 1 > maxinf) maxinf = issued - resp + 1;
            dueq.push_back(c + 3);
            idxq.push_back(issued);
            issued++;
         end
         if (dueq.size() > 0 && dueq[0] == c) begin
            rv[0]  = 1'b1;
            rid[0] = 4'(idxq[0]);
            void'(dueq.pop_front());
            void'(idxq.pop_front());
            resp++;
         end
         if (ist[0]) begin
            nist++;
            ist_c = c;
         end
         if (c == ist_c + 1) idn[0] = 1'b1;
         if (dn[0]) dcyc = c;
         tick();
      end
      rdy[0] = 1'b0;
      rv[0]  = 1'b0;
      idn[0] = 1'b0;
      chk("B_eval_load_cycle", 0, first_el, 1);
      chk("B_first_req_cycle", 0, first_mv, 3);
      chk("B_issued", 0, issued, 15);
      chk("B_max_inflight_le4", 0, int'(maxinf <= 4), 1);
      chk("B_interp_start_cnt", 0, nist, 1);
      chk("B_done_seen", 0, int'(dcyc != 0), 1);
      chk("B_err", 0, int'(er[0]), 0);
      chk("B_ready_after_fin", 0, int'(sr[0]), 1);
      chk("B_busy_after_fin", 0, int'(bz[0]), 0);
      chk("B_cycles", 0, int'(cyc[0]), dcyc);

      // Reverse-order returns with MAX_OUTST=15, a range error, and an
      // interp_done outside INTERP that must be ignored.
      issued = 0;
      nist   = 0;
      ist_c  = -10;
      dcyc   = 0;
      c_last = 1000;
      c0     = 2000;
      sv[1]  = 1'b1;
      tick();
      sv[1]  = 1'b0;
      for (int c = 1; c <= 300 && dcyc == 0; c++) begin
         rdy[1] = 1'b1;
         rv[1]  = 1'b0;
         rid[1] = 4'd0;
         idn[1] = 1'b0;
         if (mv[1]) begin
            chk("C_req_idx", issued, int'(mi[1]), issued);
            issued++;
            if (issued == 15) c_last = c;
         end
         if (c == c_last + 1) idn[1] = 1'b1;
         if (c == c_last + 2) begin
            rv[1]  = 1'b1;
            rid[1] = 4'd15;
         end
         k = c - c_last - 3;
         if (k >= 0 && k <= 14) begin
            rv[1]  = 1'b1;
            rid[1] = 4'(14 - k);
            if (k == 14) c0 = c;
         end
         if (ist[1]) begin
            nist++;
            ist_c = c;
         end
         if (c == ist_c + 1) idn[1] = 1'b1;
         if (dn[1]) dcyc = c;
         tick();
      end
      rdy[1] = 1'b0;
      rv[1]  = 1'b0;
      idn[1] = 1'b0;
      chk("C_issued", 0, issued, 15);
      chk("C_interp_start_cnt", 0, nist, 1);
      chk("C_ist_after_idx0", 0, int'(ist_c > c0 && ist_c <= c0 + 3), 1);
      chk("C_done_after_ist", 0, int'(dcyc > ist_c), 1);
      chk("C_err_sticky", 0, int'(er[1]), 1);
      chk("C_cycles", 0, int'(cyc[1]), dcyc);
      sv[1] = 1'b1;
      tick();
      sv[1] = 1'b0;
      chk("C_err_clr_on_start", 0, int'(er[1]), 0);
      chk("C_eval_load", 0, int'(el[1]), 1);
      chk("C_cycles_clr", 0, int'(cyc[1]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
